// File: rtl/gtp_tx_sched.sv
// Round-robin TX frame scheduler for one GTP lane: SOF/DATA/EOF framing with K28.5 comma idle fill.
// Build option TXARB_CSUM_EN: inserts an XOR checksum word between the last DATA word and EOF.
module gtp_tx_sched #(
    parameter int NREQ   = 4,
    parameter int MAXLEN = 255,
    parameter int GAP    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] data_in,
    input  logic [NREQ-1:0]    last_in,
    output logic [NREQ-1:0]    ack,
    output logic [15:0]        data_o,
    output logic               charisk_o,
    output logic               busy,
    output logic [2:0]         cur_id
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_EOF  = 3'd4;
`ifdef TXARB_CSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_TAIL = S_CSUM;
`else
    localparam logic [2:0] S_TAIL = S_EOF;
`endif

    localparam logic [15:0] W_IDLE   = 16'h50BC;
    localparam logic [7:0]  K_SOF    = 8'hFB;
    localparam logic [7:0]  K_EOF    = 8'hFD;
    localparam logic [7:0]  K_ERR    = 8'hFE;
    localparam logic [3:0]  GAP_MIN  = 4'(GAP);
    localparam logic [7:0]  LEN_LAST = 8'(MAXLEN - 1);

    logic [2:0]  state_reg;
    logic [15:0] data_reg;
    logic        charisk_reg;
    logic        busy_reg;
    logic        fe_reg;
    logic [2:0]  cur_id_reg;
    logic [2:0]  last_grant_reg;
    logic [3:0]  gap_reg;
    logic [7:0]  len_reg;
`ifdef TXARB_CSUM_EN
    logic [15:0] csum_reg;
`endif

    // Requester slices padded to 8 entries so the 3-bit id always indexes in range.
    logic [7:0]  req_ext;
    logic [7:0]  last_ext;
    logic [15:0] word_ext [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < NREQ) begin : g_used
                assign req_ext[gi]  = req[gi];
                assign last_ext[gi] = last_in[gi];
                assign word_ext[gi] = data_in[16*gi +: 16];
            end else begin : g_pad
                assign req_ext[gi]  = 1'b0;
                assign last_ext[gi] = 1'b0;
                assign word_ext[gi] = 16'h0000;
            end
        end
    endgenerate

    logic        req_sel;
    logic        last_sel;
    logic [15:0] data_sel;
    assign req_sel  = req_ext[cur_id_reg];
    assign last_sel = last_ext[cur_id_reg];
    assign data_sel = word_ext[cur_id_reg];

    // A granted requester that drops req is aborted rather than acked.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
            assign ack[gi] = (state_reg == S_DATA) && (cur_id_reg == 3'(gi)) && req[gi];
        end
    endgenerate

    // Round robin: rotate req so last_grant+1 sits at bit 0, take the lowest set bit.
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [3:0]        rr_base;
    logic [3:0]        rr_off;
    logic [3:0]        rr_raw;
    logic [3:0]        rr_sum;
    logic [2:0]        grant_next;
    logic              start;

    assign req_dbl = {req, req};
    assign rr_base = {1'b0, last_grant_reg} + 4'd1;
    assign req_rot = NREQ'(req_dbl >> rr_base);

    always_comb begin
        rr_off = 4'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rr_off = 4'(i);
            end
        end
        rr_raw = rr_base + rr_off;
        rr_sum = (rr_raw >= 4'(NREQ)) ? (rr_raw - 4'(NREQ)) : rr_raw;
        grant_next = rr_sum[2:0];
    end

    assign start = (gap_reg >= GAP_MIN) && (|req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            data_reg       <= W_IDLE;
            charisk_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            fe_reg         <= 1'b0;
            cur_id_reg     <= 3'd0;
            last_grant_reg <= 3'(NREQ - 1);
            gap_reg        <= 4'd15;
            len_reg        <= 8'd0;
`ifdef TXARB_CSUM_EN
            csum_reg       <= 16'h0000;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    charisk_reg <= 1'b1;
                    if (start) begin
                        data_reg       <= {5'b0, grant_next, K_SOF};
                        busy_reg       <= 1'b1;
                        cur_id_reg     <= grant_next;
                        last_grant_reg <= grant_next;
                        len_reg        <= 8'd0;
                        fe_reg         <= 1'b0;
`ifdef TXARB_CSUM_EN
                        csum_reg       <= 16'h0000;
`endif
                        state_reg      <= S_DATA;
                    end else begin
                        data_reg <= W_IDLE;
                        busy_reg <= 1'b0;
                        if (gap_reg != 4'd15) begin
                            gap_reg <= gap_reg + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (req_sel) begin
                        data_reg    <= data_sel;
                        charisk_reg <= 1'b0;
                        len_reg     <= len_reg + 8'd1;
`ifdef TXARB_CSUM_EN
                        csum_reg    <= csum_reg ^ data_sel;
`endif
                        // last_in wins over a simultaneous MAXLEN hit.
                        if (last_sel || (len_reg == LEN_LAST)) begin
                            fe_reg    <= !last_sel;
                            state_reg <= S_TAIL;
                        end
                    end else begin
`ifdef TXARB_CSUM_EN
                        data_reg    <= csum_reg;
                        charisk_reg <= 1'b0;
                        fe_reg      <= 1'b1;
                        state_reg   <= S_EOF;
`else
                        data_reg    <= {len_reg, K_ERR};
                        charisk_reg <= 1'b1;
                        gap_reg     <= 4'd0;
                        state_reg   <= S_IDLE;
`endif
                    end
                end
`ifdef TXARB_CSUM_EN
                S_CSUM: begin
                    data_reg    <= csum_reg;
                    charisk_reg <= 1'b0;
                    state_reg   <= S_EOF;
                end
`endif
                S_EOF: begin
                    data_reg    <= {len_reg, fe_reg ? K_ERR : K_EOF};
                    charisk_reg <= 1'b1;
                    gap_reg     <= 4'd0;
                    state_reg   <= S_IDLE;
                end
                default: begin
                    state_reg   <= S_IDLE;
                    data_reg    <= W_IDLE;
                    charisk_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign data_o    = data_reg;
    assign charisk_o = charisk_reg;
    assign busy      = busy_reg;
    assign cur_id    = cur_id_reg;

endmodule

// File: tb/tb_gtp_tx_sched.sv
// Randomized bench for gtp_tx_sched: requester message queues, frame scoreboard and line-protocol rules.
module tb_gtp_tx_sched;
    localparam int NREQ   = 4;
    localparam int MAXLEN = 4;
    localparam int GAP    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   data_in;
    logic [NREQ-1:0]      last_in;
    logic [NREQ-1:0]      ack;
    logic [15:0]          data_o;
    logic                 charisk_o;
    logic                 busy;
    logic [2:0]           cur_id;

    always #4 clk = ~clk;

    gtp_tx_sched #(.NREQ(NREQ), .MAXLEN(MAXLEN), .GAP(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .last_in   (last_in),
        .ack       (ack),
        .data_o    (data_o),
        .charisk_o (charisk_o),
        .busy      (busy),
        .cur_id    (cur_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Requester side: words still to be offered, and what the line must eventually carry.
    logic [15:0] drv_word  [NREQ][$];
    bit          drv_last  [NREQ][$];
    logic [15:0] exp_word  [NREQ][$];
    int          exp_len   [NREQ][$];
    bit          exp_fe    [NREQ][$];
    int          abort_k   [NREQ];
    int          acked_cnt [NREQ];

    // Line-level view of the link.
    bit              in_frame;
    bit              acking;
    int              frame_id;
    int              frame_words;
    int              frame_acks;
    int              idle_cnt;
    int              last_grant_m;
    logic [NREQ-1:0] req_s;
    logic [NREQ-1:0] ack_s;

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
        int pick;
        bit found;
        pick  = last;
        found = 0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!found && r[(last + off) % NREQ]) begin
                pick  = (last + off) % NREQ;
                found = 1;
            end
        end
        return pick;
    endfunction

    task automatic reset_model();
        in_frame     = 0;
        acking       = 0;
        frame_id     = 0;
        frame_words  = 0;
        frame_acks   = 0;
        idle_cnt     = 15;
        last_grant_m = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            drv_word[i].delete();
            drv_last[i].delete();
            exp_word[i].delete();
            exp_len[i].delete();
            exp_fe[i].delete();
            abort_k[i]   = 0;
            acked_cnt[i] = 0;
        end
    endtask

    // A message of n words is split into frames of at most MAXLEN; only the final chunk ends FD.
    task automatic push_msg(input int i, input int n, input int abort_at,
                            input logic [15:0] seed, input bit fixed);
        logic [15:0] wv;
        int rem;
        int c;
        if (drv_word[i].size() == 0) acked_cnt[i] = 0;
        for (int w = 0; w < n; w++) begin
            wv = fixed ? 16'(int'(seed) * (w + 1)) : 16'($urandom);
            drv_word[i].push_back(wv);
            drv_last[i].push_back(w == n - 1);
            exp_word[i].push_back(wv);
        end
        rem = n;
        while (rem > 0) begin
            c = (rem < MAXLEN) ? rem : MAXLEN;
            exp_len[i].push_back(c);
            exp_fe[i].push_back(c != rem);
            rem -= c;
        end
        abort_k[i] = abort_at;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = (drv_word[i].size() != 0);
            data_in[16*i +: 16] = req[i] ? drv_word[i][0] : 16'h0000;
            last_in[i]          = req[i] ? drv_last[i][0] : 1'b0;
        end
    endtask

    task automatic monitor();
        bit is_sof;
        int id;
        int el;
        bit ef;
        is_sof = charisk_o && (data_o[7:0] == 8'hFB);
        if (!in_frame) begin
            chk_val("sof_start", is_sof, (idle_cnt >= GAP) && (req_s != '0));
            if (is_sof) begin
                id = rr_pick(last_grant_m, req_s);
                chk_val("sof_word", data_o, {5'b0, 3'(id), 8'hFB});
                chk_val("sof_cur_id", cur_id, id);
                chk_val("sof_busy", busy, 1);
                in_frame     = 1;
                acking       = 1;
                frame_id     = id;
                frame_words  = 0;
                frame_acks   = 0;
                last_grant_m = id;
            end else begin
                chk_val("idle_word", {charisk_o, data_o}, {1'b1, 16'h50BC});
                chk_val("idle_busy", busy, 0);
                if (idle_cnt < 15) idle_cnt++;
            end
        end else begin
            chk_val("frame_busy", busy, 1);
            chk_val("frame_cur_id", cur_id, frame_id);
            if (!charisk_o) begin
                chk_val("data_have_exp", exp_word[frame_id].size() != 0, 1);
                if (exp_word[frame_id].size() != 0) begin
                    chk_val("data_word", data_o, exp_word[frame_id].pop_front());
                end
                frame_words++;
            end else begin
                chk_val("eof_len_sent", data_o[15:8], frame_words);
                chk_val("eof_have_exp", exp_len[frame_id].size() != 0, 1);
                if (exp_len[frame_id].size() != 0) begin
                    el = exp_len[frame_id].pop_front();
                    ef = exp_fe[frame_id].pop_front();
                    chk_val("eof_word", data_o, {el[7:0], ef ? 8'hFE : 8'hFD});
                end
                $display("[TB] frame id=%0d len=%0d end=%02h", frame_id, frame_words, data_o[7:0]);
                in_frame = 0;
                acking   = 0;
                idle_cnt = 0;
            end
        end
    endtask

    task automatic cycle(input bit rand_en);
        logic [NREQ-1:0] ack_exp;
        int rem;
        int i;
        int n;
        @(negedge clk);
        req_s   = req;
        ack_exp = '0;
        if (acking && req[frame_id]) ack_exp[frame_id] = 1'b1;
        chk_val("ack", ack, ack_exp);
        if (acking) begin
            if (!req[frame_id]) begin
                acking = 0;
            end else begin
                frame_acks++;
                if (last_in[frame_id] || frame_acks == MAXLEN) acking = 0;
            end
        end
        ack_s = ack;
        @(posedge clk);
        #1;
        monitor();
        for (int k = 0; k < NREQ; k++) begin
            if (ack_s[k] && drv_word[k].size() != 0) begin
                void'(drv_word[k].pop_front());
                void'(drv_last[k].pop_front());
                acked_cnt[k]++;
            end
            // Drop req mid-frame once the armed number of words has been taken.
            if (abort_k[k] != 0 && acked_cnt[k] == abort_k[k]) begin
                rem = drv_word[k].size();
                drv_word[k].delete();
                drv_last[k].delete();
                for (int r = 0; r < rem; r++) void'(exp_word[k].pop_back());
                exp_len[k][exp_len[k].size() - 1] = abort_k[k];
                exp_fe[k][exp_fe[k].size() - 1]   = 1'b1;
                abort_k[k] = 0;
            end
        end
        if (rand_en && $urandom_range(0, 3) == 0) begin
            i = $urandom_range(0, NREQ - 1);
            n = $urandom_range(1, 10);
            if (drv_word[i].size() == 0) begin
                if (n >= 2 && n <= MAXLEN && $urandom_range(0, 4) == 0)
                    push_msg(i, n, $urandom_range(1, n - 1), 16'h0, 0);
                else
                    push_msg(i, n, 0, 16'h0, 0);
            end else if (abort_k[i] == 0 && drv_word[i].size() < 20) begin
                push_msg(i, n, 0, 16'h0, 0);
            end
        end
        drive();
    endtask

    task automatic chk_reset();
        chk_val("rst_data", data_o, 16'h50BC);
        chk_val("rst_charisk", charisk_o, 1);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_cur_id", cur_id, 0);
        chk_val("rst_ack", ack, 0);
    endtask

    task automatic chk_drained(input string tag);
        int left;
        left = 0;
        for (int i = 0; i < NREQ; i++) left += exp_word[i].size() + exp_len[i].size();
        chk_val(tag, left, 0);
    endtask

    initial begin
        int t;
        rst     = 1'b1;
        req     = '0;
        data_in = '0;
        last_in = '0;
        reset_model();
        @(posedge clk);
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single 3-word frame from requester 0: 1111, 2222, 3333.
        push_msg(0, 3, 0, 16'h1111, 1);
        drive();
        repeat (12) cycle(0);

        // Requester 3 drops req after two acked words.
        push_msg(3, 4, 2, 16'hA001, 1);
        drive();
        repeat (12) cycle(0);

        // Truncation: requester 1 streams 6 words with MAXLEN=4.
        push_msg(1, 6, 0, 16'h0101, 1);
        drive();
        repeat (20) cycle(0);
        chk_drained("directed_drain");

        repeat (3000) cycle(1);
        repeat (300) cycle(0);
        chk_drained("random_drain");

        // Reset in the middle of a frame, then a fresh request from requester 1.
        push_msg(2, 4, 0, 16'h0202, 1);
        drive();
        t = 0;
        while (!(in_frame && frame_words >= 1) && t < 50) begin
            cycle(0);
            t++;
        end
        chk_val("midframe_reached", in_frame && frame_words >= 1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset();
        reset_model();
        drive();
        rst = 1'b0;
        push_msg(1, 2, 0, 16'h0B0B, 1);
        drive();
        cycle(0);
        chk_val("post_rst_sof", data_o, 16'h01FB);
        repeat (15) cycle(0);
        chk_drained("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
